// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback stage: opcodes, flag layout,
// branch condition codes, the buffered entry format and condition evaluation.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_REG_AW = 3;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_NONE = 4'b1111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_CS = 3'b101;
    localparam logic [2:0] COND_CC = 3'b110;
    localparam logic [2:0] COND_VS = 3'b111;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] data;
        logic [ALU_REG_AW-1:0] dest;
        logic                  we;
        logic                  taken;
        logic [ALU_DATA_W-1:0] tgt;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // Evaluates a branch condition code against a {S,Z,C,V} flag vector.
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
        logic res;
        res = 1'b0;
        case (cond)
            COND_AL: res = 1'b1;
            COND_EQ: res = f[FLAG_Z];
            COND_NE: res = ~f[FLAG_Z];
            COND_LT: res = f[FLAG_S] ^ f[FLAG_V];
            COND_GE: res = ~(f[FLAG_S] ^ f[FLAG_V]);
            COND_CS: res = f[FLAG_C];
            COND_CC: res = ~f[FLAG_C];
            COND_VS: res = f[FLAG_V];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Bus between the ALU, the writeback stage and the register file / fetch logic.
// master drives ALU results and accepts writeback; slave is the stage itself.
interface alu_writeback_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        flag_out;
    logic [3:0]        s_alu;
    logic              wb_en_in;
    logic [REG_AW-1:0] wb_dest_in;
    logic              br_en;
    logic [2:0]        br_cond;
    logic [DATA_W-1:0] br_tgt;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] wb_dest;
    logic              wb_we;
    logic              br_taken;
    logic [DATA_W-1:0] br_addr;
    logic [3:0]        flag_reg;

    modport master (
        output in_valid, alu_out, flag_out, s_alu, wb_en_in, wb_dest_in,
               br_en, br_cond, br_tgt, out_ready,
        input  in_ready, out_valid, wb_data, wb_dest, wb_we, br_taken,
               br_addr, flag_reg
    );

    modport slave (
        input  in_valid, alu_out, flag_out, s_alu, wb_en_in, wb_dest_in,
               br_en, br_cond, br_tgt, out_ready,
        output in_ready, out_valid, wb_data, wb_dest, wb_we, br_taken,
               br_addr, flag_reg
    );
endinterface

// File: rtl/alu_writeback_stage_wb_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready is a register so the upstream
// never sees a combinational path from out_ready.
//   state | meaning
//   EMPTY | no entries held
//   ONE   | head valid, tail free
//   TWO   | head and tail valid, input stalled
module wb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         in_ready_q;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state != ST_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = head;

    // Occupancy transitions from push/pop.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_TWO;
                else if (!push && pop) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // State register; in_ready is held low through reset and rises one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
        end
    end

    // Entry storage: new data goes to head when it will be the oldest entry, else to tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (push) head <= in_data;
                ST_ONE: begin
                    if (push && pop)  head <= in_data;
                    else if (push)    tail <= in_data;
                end
                ST_TWO:   if (pop) head <= tail;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: owns the architectural flag register, resolves
// conditional branches at accept time and buffers results for writeback.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_writeback_stage_if.slave  bus
);

    logic      [3:0] flag_q;
    logic      [3:0] eff_flags;
    logic            accept;
    logic            buf_in_ready;
    logic            buf_out_valid;
    logic            has_op;
    wb_entry_t       in_entry;
    wb_entry_t       head_entry;

    assign has_op    = (bus.s_alu != OP_NONE);
    assign accept    = bus.in_valid && buf_in_ready;
    // The instruction's own flags are forwarded so a compare+branch resolves in one step.
    assign eff_flags = has_op ? bus.flag_out : flag_q;

    // Pack the incoming instruction with its resolved branch outcome.
    always_comb begin
        in_entry       = '0;
        in_entry.data  = bus.alu_out;
        in_entry.dest  = bus.wb_dest_in;
        in_entry.we    = bus.wb_en_in;
        in_entry.taken = bus.br_en && cond_met(bus.br_cond, eff_flags);
        in_entry.tgt   = bus.br_tgt;
    end

    // Flags follow the ALU in order: updated at accept, not when the entry drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 4'b0000;
        end else if (accept && has_op) begin
            flag_q <= bus.flag_out;
        end
    end

    wb_skid_buf #(.W(ENTRY_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (in_entry),
        .out_valid (buf_out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head_entry)
    );

    assign bus.in_ready  = buf_in_ready;
    assign bus.out_valid = buf_out_valid;
    assign bus.wb_data   = head_entry.data[DATA_W-1:0];
    assign bus.wb_dest   = head_entry.dest[REG_AW-1:0];
    assign bus.wb_we     = buf_out_valid && head_entry.we;
    assign bus.br_taken  = buf_out_valid && head_entry.taken;
    assign bus.br_addr   = head_entry.tgt[DATA_W-1:0];
    assign bus.flag_reg  = flag_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: the driver predicts each accepted
// entry from a flag/branch model and queues it; the monitor checks on each pop.
module tb_alu_writeback_stage;

    localparam logic [3:0] NONE = 4'hF;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        we;
        logic        taken;
        logic [15:0] tgt;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_writeback_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

    alu_writeback_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    logic [3:0] mflags = 4'b0000;
    logic [3:0] pend_f = 4'b0000;
    bit         pend_v = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_cond(input logic [2:0] c, input logic [3:0] f);
        bit s, z, cy, v;
        s = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return s != v;
            3'd4: return s == v;
            3'd5: return cy;
            3'd6: return !cy;
            default: return v;
        endcase
    endfunction

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input bit v, input bit ordy, input logic [15:0] alu, input logic [3:0] fl,
                        input logic [3:0] op, input bit we, input logic [2:0] dst, input bit be,
                        input logic [2:0] cnd, input logic [15:0] tgt, output bit acc);
        logic [3:0] eff;
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_v) begin
            mflags = pend_f;
            pend_v = 1'b0;
        end
        bus.in_valid   = v;
        bus.out_ready  = ordy;
        bus.alu_out    = alu;
        bus.flag_out   = fl;
        bus.s_alu      = op;
        bus.wb_en_in   = we;
        bus.wb_dest_in = dst;
        bus.br_en      = be;
        bus.br_cond    = cnd;
        bus.br_tgt     = tgt;
        acc = v && bus.in_ready;
        if (acc) begin
            eff     = (op != NONE) ? fl : mflags;
            e.data  = alu;
            e.dest  = dst;
            e.we    = we;
            e.taken = be && ref_cond(cnd, eff);
            e.tgt   = tgt;
            q.push_back(e);
            if (op != NONE) begin
                pend_v = 1'b1;
                pend_f = fl;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(1'b0, ordy, 16'h0, 4'h0, NONE, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, a);
    endtask

    task automatic rand_step(input int vpct, input int rpct);
        bit a;
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? NONE : 4'($urandom_range(0, 6));
        step($urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct,
             16'($urandom), 4'($urandom), op, 1'($urandom), 3'($urandom),
             1'($urandom), 3'($urandom), 16'($urandom), a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic clear_model();
        q.delete();
        mflags = 4'b0000;
        pend_v = 1'b0;
    endtask

    // Monitor: compares each popped head against the scoreboard and tracks the flag register.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("flag_reg", bus.flag_reg, mflags);
                if (!bus.out_valid) begin
                    chk("wb_we_qualified", bus.wb_we, 1'b0);
                    chk("br_taken_qualified", bus.br_taken, 1'b0);
                end else if (bus.out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("wb_data", bus.wb_data, e.data);
                        chk("wb_dest", bus.wb_dest, e.dest);
                        chk("wb_we", bus.wb_we, e.we);
                        chk("br_taken", bus.br_taken, e.taken);
                        chk("br_addr", bus.br_addr, e.tgt);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit a;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_out = '0; bus.flag_out = '0;
        bus.s_alu = NONE; bus.wb_en_in = 1'b0; bus.wb_dest_in = '0; bus.br_en = 1'b0;
        bus.br_cond = '0; bus.br_tgt = '0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_flag_reg", bus.flag_reg, 4'b0000);
        chk("rst_wb_data", bus.wb_data, 16'h0);
        #21 rst_n = 1'b1;
        idle(1'b0);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        // Single op with one-cycle latency
        step(1'b1, 1'b0, 16'h0005, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0, a);
        chk("single_accepted", a, 1'b1);
        idle(1'b0);
        chk("single_out_valid", bus.out_valid, 1'b1);
        chk("single_wb_data", bus.wb_data, 16'h0005);
        chk("single_wb_dest", bus.wb_dest, 3'd3);
        chk("single_wb_we", bus.wb_we, 1'b1);
        drain();

        // Backpressure: third push must be refused
        step(1'b1, 1'b0, 16'h1111, 4'b0001, 4'b0000, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0, a);
        chk("bp_acc1", a, 1'b1);
        step(1'b1, 1'b0, 16'h2222, 4'b0010, 4'b0000, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, a);
        chk("bp_acc2", a, 1'b1);
        step(1'b1, 1'b0, 16'h3333, 4'b0011, 4'b0000, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0, a);
        chk("bp_acc3_refused", a, 1'b0);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        chk("bp_hold_data", bus.wb_data, 16'h1111);
        idle(1'b0);
        chk("bp_hold_data2", bus.wb_data, 16'h1111);
        drain();

        // Forwarded branch on the SUB's own Z flag
        step(1'b1, 1'b0, 16'h0000, 4'b0100, 4'b0001, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0040, a);
        idle(1'b0);
        chk("fwd_br_taken", bus.br_taken, 1'b1);
        chk("fwd_br_addr", bus.br_addr, 16'h0040);
        chk("fwd_flag_reg", bus.flag_reg, 4'b0100);
        drain();

        // OP_NONE keeps flags and branches on the stored ones
        step(1'b1, 1'b1, 16'h0007, 4'b1000, 4'b0000, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0, a);
        step(1'b1, 1'b1, 16'h0008, 4'b0000, NONE, 1'b0, 3'd0, 1'b1, 3'd3, 16'h0123, a);
        idle(1'b0);
        chk("none_flag_reg", bus.flag_reg, 4'b1000);
        chk("none_br_taken", bus.br_taken, 1'b1);
        chk("none_br_addr", bus.br_addr, 16'h0123);
        drain();

        // Streaming: one transfer per cycle with no stall
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 16'(16'hA000 + i), 4'(i), 4'(i % 7), 1'b1, 3'(i), 1'b1, 3'(i), 16'(i * 3), a);
            chk("stream_acc", a, 1'b1);
            chk("stream_in_ready", bus.in_ready, 1'b1);
            if (i > 0) chk("stream_out_valid", bus.out_valid, 1'b1);
        end
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) rand_step(70, 65);
        drain();

        // Reset with two entries held
        step(1'b1, 1'b0, 16'h0AAA, 4'b1010, 4'b0000, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0, a);
        step(1'b1, 1'b0, 16'h0BBB, 4'b0110, 4'b0000, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, a);
        idle(1'b0);
        chk("pre_rst_full", bus.in_ready, 1'b0);
        chk("pre_rst_flags", bus.flag_reg, 4'b0110);
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_flag_reg", bus.flag_reg, 4'b0000);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk("midrst_wb_we", bus.wb_we, 1'b0);
        chk("midrst_wb_data", bus.wb_data, 16'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(1'b1);
        chk("midrst_post_in_ready", bus.in_ready, 1'b1);
        chk("midrst_post_out_valid", bus.out_valid, 1'b0);

        for (int i = 0; i < 100; i++) rand_step(60, 50);
        drain();
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
